// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-side, decode-side and control signals.
// The master modport is the fetch unit; the slave modport is memory/decode/controller.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a memory read is outstanding while mem_req=1, with mem_addr held stable.
  // It completes on the first cycle that mem_ack=1, when mem_rdata is valid. An instruction
  // is held while fetch_ready=1, with inst/inst_pc stable. It is consumed on the first cycle
  // that decode_ack=1, unless redirect_valid is also 1 in that cycle, in which case it is
  // dropped.
  logic            stall_fc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            fetch_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            decode_ack;
  logic [31:0]     fetch_count;

  modport master (
    input  stall_fc, redirect_valid, redirect_pc, mem_ack, mem_rdata, decode_ack,
    output mem_req, mem_addr, fetch_ready, inst, inst_pc, fetch_count
  );

  modport slave (
    output stall_fc, redirect_valid, redirect_pc, mem_ack, mem_rdata, decode_ack,
    input  mem_req, mem_addr, fetch_ready, inst, inst_pc, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding memory read, one-entry holding register.
// Optional delivered-instruction counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            drop_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.redirect_valid) begin
            pc_q <= bus.redirect_pc;
          end else if (!bus.stall_fc) begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // pc_q stays put until the ack so mem_addr is stable for the whole request.
          if (bus.mem_ack) begin
            if (drop_q || bus.redirect_valid) begin
              pc_q    <= bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
              drop_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              inst_q    <= bus.mem_rdata;
              inst_pc_q <= pc_q;
              pc_q      <= pc_q + XLEN'(4);
              state_q   <= S_HOLD;
            end
          end else if (bus.redirect_valid) begin
            drop_q    <= 1'b1;
            pend_pc_q <= bus.redirect_pc;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_pc;
            state_q <= S_IDLE;
          end else if (bus.decode_ack) begin
            state_q <= bus.stall_fc ? S_IDLE : S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_addr    = pc_q;
  assign bus.fetch_ready = (state_q == S_HOLD);
  assign bus.inst        = inst_q;
  assign bus.inst_pc     = inst_pc_q;
  assign dbg_state_o     = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (state_q == S_HOLD && bus.decode_ack && !bus.redirect_valid) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder, stimulus sequence, delivery scoreboard.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int mem_delay = 0;
  int mem_cnt = 0;
  logic [63:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h0000_0100) ? 32'hDEAD_BEEF : addr + 32'h1000_0000;
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef FETCH_PERF_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Memory responder: acks after mem_delay extra cycles of an outstanding request.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        bus.mem_rdata = mem_word(bus.mem_addr);
        if (mem_cnt == mem_delay) begin
          bus.mem_ack = 1'b1;
          mem_cnt     = 0;
        end else begin
          bus.mem_ack = 1'b0;
          mem_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        mem_cnt     = 0;
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the expected queue.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && bus.fetch_ready && bus.decode_ack && !bus.redirect_valid) begin
        exp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver: unexpected pc=%h inst=%h, nothing expected", bus.inst_pc, bus.inst);
        end else begin
          exp = exp_q.pop_front();
          chk("deliver", {bus.inst_pc, bus.inst}, exp);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   64'(bus.mem_req), 64'd0);
    chk({tag, "_addr"},  64'(bus.mem_addr), 64'h100);
    chk({tag, "_rdy"},   64'(bus.fetch_ready), 64'd0);
    chk({tag, "_inst"},  64'(bus.inst), 64'd0);
    chk({tag, "_ipc"},   64'(bus.inst_pc), 64'd0);
    chk({tag, "_cnt"},   64'(bus.fetch_count), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.stall_fc       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.decode_ack     = 1'b0;
    repeat (3) step();
    chk_reset_state("rst");
    exp_q.push_back({32'h100, 32'hDEAD_BEEF});
    reset = 1'b0;

    // Zero-wait memory: request in cycle 1, instruction held in cycle 2.
    step(); bus.decode_ack = 1'b1;
    chk("c1_req", 64'(bus.mem_req), 64'd1);
    chk("c1_addr", 64'(bus.mem_addr), 64'h100);
    chk("c1_rdy", 64'(bus.fetch_ready), 64'd0);
    step(); exp_q.push_back({32'h104, 32'h1000_0104});
    chk("c2_rdy", 64'(bus.fetch_ready), 64'd1);
    chk("c2_inst", 64'(bus.inst), 64'hDEAD_BEEF);
    chk("c2_ipc", 64'(bus.inst_pc), 64'h100);
    step();
    chk("c3_req", 64'(bus.mem_req), 64'd1);
    chk("c3_addr", 64'(bus.mem_addr), 64'h104);
    step(); bus.stall_fc = 1'b1;
    chk("c4_rdy", 64'(bus.fetch_ready), 64'd1);

    // Stall after the accept keeps fetch idle.
    step(); bus.decode_ack = 1'b0; mem_delay = 3;
    chk("c5_req", 64'(bus.mem_req), 64'd0);
    chk("c5_rdy", 64'(bus.fetch_ready), 64'd0);
    for (int k = 6; k <= 7; k++) begin
      step();
      chk($sformatf("c%0d_stall_req", k), 64'(bus.mem_req), 64'd0);
    end
    bus.stall_fc = 1'b0;

    // Three-cycle ack delay: request held for four cycles at a constant address.
    exp_q.push_back({32'h108, 32'h1000_0108});
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("slow_req%0d", i), 64'(bus.mem_req), 64'd1);
      chk($sformatf("slow_addr%0d", i), 64'(bus.mem_addr), 64'h108);
      chk($sformatf("slow_rdy%0d", i), 64'(bus.fetch_ready), 64'd0);
    end
    mem_delay = 0;
    step();
    chk("c12_rdy", 64'(bus.fetch_ready), 64'd1);
    chk("c12_inst", 64'(bus.inst), 64'h1000_0108);
    chk("c12_ipc", 64'(bus.inst_pc), 64'h108);
    step(); bus.decode_ack = 1'b1;
    chk("c13_hold_inst", 64'(bus.inst), 64'h1000_0108);
    step(); bus.decode_ack = 1'b0;
    chk("c14_addr", 64'(bus.mem_addr), 64'h10C);

    // Redirect and decode_ack together in HOLD: instruction dropped, not counted.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; bus.decode_ack = 1'b1;
    chk("c15_rdy", 64'(bus.fetch_ready), 64'd1);
    chk("c15_inst", 64'(bus.inst), 64'h1000_010C);
    step(); bus.redirect_valid = 1'b0; bus.decode_ack = 1'b0; mem_delay = 3;
    chk("c16_rdy", 64'(bus.fetch_ready), 64'd0);
    chk("c16_req", 64'(bus.mem_req), 64'd0);
    chk("c16_pc", 64'(bus.mem_addr), 64'h200);
    chk("c16_state", 64'(dbg_state), 64'd0);
    chk("c16_cnt", 64'(bus.fetch_count), 64'(exp_count()));
    step();
    chk("c17_addr", 64'(bus.mem_addr), 64'h200);

    // Redirects during an outstanding request: ack data discarded, last target wins.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2F0;
    chk("c18_addr", 64'(bus.mem_addr), 64'h200);
    step(); bus.redirect_pc = 32'h300;
    chk("c19_addr", 64'(bus.mem_addr), 64'h200);
    step(); bus.redirect_valid = 1'b0;
    chk("c20_req", 64'(bus.mem_req), 64'd1);
    chk("c20_addr", 64'(bus.mem_addr), 64'h200);
    step(); mem_delay = 0; bus.decode_ack = 1'b1;
    chk("c21_req", 64'(bus.mem_req), 64'd0);
    chk("c21_rdy", 64'(bus.fetch_ready), 64'd0);
    chk("c21_addr", 64'(bus.mem_addr), 64'h300);
    chk("c21_inst", 64'(bus.inst), 64'h1000_010C);
    step(); exp_q.push_back({32'h300, 32'h1000_0300});
    chk("c22_req", 64'(bus.mem_req), 64'd1);
    chk("c22_addr", 64'(bus.mem_addr), 64'h300);
    step(); bus.stall_fc = 1'b1;
    chk("c23_rdy", 64'(bus.fetch_ready), 64'd1);

    // PC wrap from the top of the address space.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    chk("c24_req", 64'(bus.mem_req), 64'd0);
    chk("c24_addr", 64'(bus.mem_addr), 64'h304);
    step(); bus.redirect_valid = 1'b0; bus.stall_fc = 1'b0;
    chk("c25_addr", 64'(bus.mem_addr), 64'hFFFF_FFFC);
    chk("c25_req", 64'(bus.mem_req), 64'd0);
    step(); exp_q.push_back({32'hFFFF_FFFC, 32'h0FFF_FFFC}); bus.stall_fc = 1'b1;
    chk("c26_req", 64'(bus.mem_req), 64'd1);
    chk("c26_addr", 64'(bus.mem_addr), 64'hFFFF_FFFC);
    step();
    chk("c27_ipc", 64'(bus.inst_pc), 64'hFFFF_FFFC);
    step(); bus.stall_fc = 1'b0; mem_delay = 5;
    chk("c28_wrap_addr", 64'(bus.mem_addr), 64'h0);
    chk("c28_req", 64'(bus.mem_req), 64'd0);
    chk("c28_cnt", 64'(bus.fetch_count), 64'(exp_count()));

    // Reset in the middle of an outstanding request.
    step(); reset = 1'b1;
    chk("c29_req", 64'(bus.mem_req), 64'd1);
    chk("c29_addr", 64'(bus.mem_addr), 64'h0);
    step(); exp_cnt = 0;
    chk_reset_state("midrst");
    repeat (2) step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
